ifu_predecode_check: RTL
========================

IFU_PREDECODE_CHECK -- requirements
Module: ifu_predecode_check

Interface
REQ-001 The block SHALL have parameter PREDICT_WIDTH, default 4, giving slots per fetch bundle; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the PC/target width.
REQ-003 The block SHALL have parameter FTQ_IDX_WIDTH, default 6, giving the FTQ index width.
REQ-004 The block SHALL have these ports, one per line, as name, direction, width, meaning; one clock, reset asynchronous active-low:
  clk_i  in  1  clock
  rst_ni  in  1  asynchronous active-low reset
  flush_i  in  1  drop all in-flight bundles
  in_valid_i / in_ready_o  in / out  1 / 1  input handshake
  in_pc_i  in  XLEN  PC of slot 0 (4-byte aligned)
  in_inst_i  in  PREDICT_WIDTH*32  slot i at bits [32i+31:32i]
  in_ftq_idx_i  in  FTQ_IDX_WIDTH  FTQ entry of bundle
  in_pred_taken_i  in  1  predictor said taken
  in_pred_slot_i  in  clog2(PREDICT_WIDTH)  predicted taken slot
  in_pred_target_i  in  XLEN  predicted target
  out_valid_o / out_ready_i  out / in  1 / 1  output handshake
  out_pd_o  out  PREDICT_WIDTH*8  per-slot PreDecodeInfo_t {valid,isRVC,brType[3:0],isCall,isRet}, slot i at [8i+7:8i]
  out_inst_valid_o  out  PREDICT_WIDTH  slots to be issued
  wb_valid_o, wb_mispredict_o, wb_target_o, wb_ftq_idx_o  out  1,1,XLEN,FTQ_IDX_WIDTH  IfuWbInfo_t fields to FTQ

Function
REQ-005 The block SHALL be a two-stage pipeline: S1 register (predecode + check), S2 output register; an unstalled bundle accepted in cycle N SHALL appear on out_valid_o in cycle N+2.
REQ-006 Full throughput: in_ready_o SHALL equal !s1_valid || !s2_valid || out_ready_i; S2 holds while out_valid_o && !out_ready_i; output fields stable while stalled.
REQ-007 Per-slot opcode decode (inst[6:0]): 1101111 -> brType 1 (JAL), 1100111 -> 2 (JALR), 1100011 -> 3 (BRANCH), else 0; isRVC SHALL be 0.
REQ-008 isCall SHALL be 1 for JAL/JALR with rd in {x1,x5}; isRet SHALL be 1 for JALR with rd==x0 and rs1 in {x1,x5}; both 0 otherwise.
REQ-009 Slot i PC SHALL be in_pc_i + 4*i, modulo 2^XLEN; JAL target = slot PC + sign-extended 21-bit J-immediate, modulo 2^XLEN.
REQ-010 j = lowest-index JAL slot (priority encode); s = in_pred_slot_i; check in priority order:
  a) JAL at j and (!pred_taken or s > j): mispredict, target = JAL target of j, cut slot k=j.
  b) pred_taken and slot s brType 0: mispredict, target = PC(s)+4, k=s.
  c) pred_taken, slot s is JAL (s==j), pred_target != JAL target: mispredict, target = JAL target, k=s.
  d) otherwise no mispredict; wb_target_o = pred_target if taken else in_pc_i + 4*PREDICT_WIDTH; k=s if taken else PREDICT_WIDTH-1.
REQ-011 out_inst_valid_o[i] and out_pd_o valid bit of slot i SHALL be 1 iff i <= k.
REQ-012 JALR/BRANCH targets SHALL never be checked (their taken prediction is trusted).
REQ-013 wb_valid_o SHALL pulse for exactly one cycle per bundle, in the cycle out_valid_o && out_ready_i, carrying that bundle's ftq_idx, mispredict, target.
REQ-014 flush_i SHALL synchronously clear s1_valid and s2_valid next edge, override a simultaneous input accept, and force wb_valid_o 0 in the flush cycle.
REQ-015 The block SHALL NOT self-flush after a mispredict; the upstream FTQ issues flush_i.

Reset
REQ-016 While rst_ni is low, s1_valid, s2_valid, out_valid_o, wb_valid_o SHALL be 0 immediately (asynchronous); in_ready_o SHALL be 1; data registers are don't-care.
REQ-017 Reset asserted mid-stall SHALL discard held bundles; no wb_valid_o pulse SHALL follow deassertion until a new bundle completes.

Verification
REQ-018 PC=0x1000, 4 NOPs (0x00000013), not taken, idx 5, out_ready=1 -> cycle N+2: inst_valid 0xF, wb mispredict 0, target 0x1010, ftq_idx 5.
REQ-019 PC=0x2000, slot1 = 0x008000EF (jal x1,+8), not taken -> mispredict 1, target 0x200C, inst_valid 0x3, slot1 brType 1, isCall 1.
REQ-020 PC=0x3000, slot2 = 0x00008067 (ret), predicted taken slot 2 target 0x4444 -> mispredict 0, target 0x4444, slot2 isRet 1, inst_valid 0x7.
REQ-021 Predicted taken slot 3 on NOP, PC=0x5000 -> mispredict 1, target 0x5010; JAL at slot 0 with pred slot 2 -> case a, k=0.
REQ-022 Back-to-back 8 bundles, out_ready toggling 1010..., flush_i mid-stream and rst_ni low mid-stall -> no loss/duplication outside flush, one wb pulse per delivered bundle, none after flush/reset.

Source files
------------

// File: rtl/ifu_predecode_check.sv
// Fetch-bundle predecode and early JAL/predictor sanity check.
// Two-stage pipeline: S1 holds the raw bundle; the check runs on S1 and the result is registered in S2.
module ifu_pd_slot #(
  parameter int XLEN = 32,
  parameter int IDX  = 0
) (
  input  logic [XLEN-1:0] base_pc_i,
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      pd_o,       // {isRVC, brType[3:0], isCall, isRet}
  output logic            is_jal_o,
  output logic [XLEN-1:0] jal_tgt_o
);
  logic [6:0]  opc;
  logic [4:0]  rd, rs1;
  logic [3:0]  br_type;
  logic        is_jalr, link_rd, link_rs1;
  logic [20:0] jimm;

  assign opc      = inst_i[6:0];
  assign rd       = inst_i[11:7];
  assign rs1      = inst_i[19:15];
  assign is_jal_o = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign br_type  = is_jal_o ? 4'd1 : is_jalr ? 4'd2 : (opc == 7'b1100011) ? 4'd3 : 4'd0;
  assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign pd_o     = {1'b0, br_type, (is_jal_o || is_jalr) && link_rd,
                     is_jalr && (rd == 5'd0) && link_rs1};

  assign pc_o      = base_pc_i + XLEN'(4 * IDX);
  assign jimm      = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign jal_tgt_o = pc_o + {{(XLEN-21){jimm[20]}}, jimm};
endmodule

module ifu_predecode_check #(
  parameter int PREDICT_WIDTH = 4,
  parameter int XLEN          = 32,
  parameter int FTQ_IDX_WIDTH = 6,
  localparam int SW = (PREDICT_WIDTH > 1) ? $clog2(PREDICT_WIDTH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [PREDICT_WIDTH*32-1:0] in_inst_i,
  input  logic [FTQ_IDX_WIDTH-1:0]   in_ftq_idx_i,
  input  logic                       in_pred_taken_i,
  input  logic [SW-1:0]              in_pred_slot_i,
  input  logic [XLEN-1:0]            in_pred_target_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PREDICT_WIDTH*8-1:0] out_pd_o,
  output logic [PREDICT_WIDTH-1:0]   out_inst_valid_o,
  output logic                       wb_valid_o,
  output logic                       wb_mispredict_o,
  output logic [XLEN-1:0]            wb_target_o,
  output logic [FTQ_IDX_WIDTH-1:0]   wb_ftq_idx_o
);
  typedef struct packed {
    logic [XLEN-1:0]                pc;
    logic [PREDICT_WIDTH-1:0][31:0] inst;
    logic [FTQ_IDX_WIDTH-1:0]       ftq_idx;
    logic                           taken;
    logic [SW-1:0]                  slot;
    logic [XLEN-1:0]                target;
  } s1_t;

  s1_t s1_q;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s2_en, s1_load;

  logic [PREDICT_WIDTH-1:0][XLEN-1:0] slot_pc, jal_tgt;
  logic [PREDICT_WIDTH-1:0][6:0]      slot_pd;
  logic [PREDICT_WIDTH-1:0]           is_jal;

  logic [PREDICT_WIDTH-1:0][7:0] pd_d, pd_q;
  logic [PREDICT_WIDTH-1:0]      iv_d, iv_q;
  logic                          mis_d, mis_q;
  logic [XLEN-1:0]               tgt_d, tgt_q;
  logic [FTQ_IDX_WIDTH-1:0]      ftq_q;
  logic                          has_j;
  logic [SW-1:0]                 j, k;

  for (genvar i = 0; i < PREDICT_WIDTH; i++) begin : g_slot
    ifu_pd_slot #(.XLEN(XLEN), .IDX(i)) u_slot (
      .base_pc_i (s1_q.pc),
      .inst_i    (s1_q.inst[i]),
      .pc_o      (slot_pc[i]),
      .pd_o      (slot_pd[i]),
      .is_jal_o  (is_jal[i]),
      .jal_tgt_o (jal_tgt[i])
    );
  end

  // Only the earliest JAL matters: anything after it is never fetched.
  always_comb begin
    has_j = 1'b0;
    j     = '0;
    for (int i = PREDICT_WIDTH - 1; i >= 0; i--) begin
      if (is_jal[i]) begin
        has_j = 1'b1;
        j     = SW'(i);
      end
    end
    mis_d = 1'b0;
    tgt_d = s1_q.taken ? s1_q.target : s1_q.pc + XLEN'(4 * PREDICT_WIDTH);
    k     = s1_q.taken ? s1_q.slot : SW'(PREDICT_WIDTH - 1);
    if (has_j && (!s1_q.taken || s1_q.slot > j)) begin
      mis_d = 1'b1;
      tgt_d = jal_tgt[j];
      k     = j;
    end else if (s1_q.taken && slot_pd[s1_q.slot][5:2] == 4'd0) begin
      mis_d = 1'b1;
      tgt_d = slot_pc[s1_q.slot] + XLEN'(4);
      k     = s1_q.slot;
    end else if (s1_q.taken && is_jal[s1_q.slot] && s1_q.target != jal_tgt[s1_q.slot]) begin
      mis_d = 1'b1;
      tgt_d = jal_tgt[s1_q.slot];
      k     = s1_q.slot;
    end
    for (int i = 0; i < PREDICT_WIDTH; i++) begin
      iv_d[i] = (SW'(i) <= k);
      pd_d[i] = {iv_d[i], slot_pd[i]};
    end
  end

  assign s2_en      = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_en;
  assign s1_load    = in_valid_i && in_ready_o;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready_o) s1_valid_d = in_valid_i;
      if (s2_en)      s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      pd_q       <= '0;
      iv_q       <= '0;
      mis_q      <= 1'b0;
      tgt_q      <= '0;
      ftq_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load)
        s1_q <= '{pc: in_pc_i, inst: in_inst_i, ftq_idx: in_ftq_idx_i, taken: in_pred_taken_i,
                  slot: in_pred_slot_i, target: in_pred_target_i};
      if (s2_en && s1_valid_q) begin
        pd_q  <= pd_d;
        iv_q  <= iv_d;
        mis_q <= mis_d;
        tgt_q <= tgt_d;
        ftq_q <= s1_q.ftq_idx;
      end
    end
  end

  assign out_valid_o      = s2_valid_q;
  assign out_pd_o         = pd_q;
  assign out_inst_valid_o = iv_q;
  assign wb_valid_o       = s2_valid_q && out_ready_i && !flush_i;
  assign wb_mispredict_o  = mis_q;
  assign wb_target_o      = tgt_q;
  assign wb_ftq_idx_o     = ftq_q;
endmodule
